tdp_ram_param: RTL and testbench

- Parametrised true dual-port synchronous RAM. Successor to the fixed 8-bit x 20-word dual-port memory.
- Two fully independent read/write ports (A, B) share one array on one clock.
- Adds explicit collision arbitration, a read-valid strobe, out-of-range protection and a sequenced post-reset memory clear with a busy flag.
- Sits between the test/host agents and any block needing a shared scratchpad.

---
 rtl/tdp_ram_pkg.sv | 23 ++
 rtl/tdp_ram_clear_seq.sv | 60 ++++++
 rtl/tdp_ram_param.sv | 165 ++++++++++++++++
 tb/tb_tdp_ram_param.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdp_ram_pkg.sv
// Shared types and elaboration helpers for the parametrised true dual-port RAM.
// Parity helper is used only when TDP_RAM_PARITY_EN is defined.
package tdp_ram_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

   // Even parity: the stored bit makes the total number of ones even.
   function automatic logic even_parity(input logic [63:0] data);
      return ^data;
   endfunction

   function automatic bit addr_fits(input int addr_w, input int depth);
      return (longint'(1) << addr_w) >= longint'(depth);
   endfunction

   function automatic int idx_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/tdp_ram_clear_seq.sv
// Post-reset clear sequencer: walks every word once, writing the clear value,
// and holds busy high until the last word has been written.
module tdp_ram_clear_seq
   import tdp_ram_pkg::*;
#(
   parameter int DEPTH = 20,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   output logic             busy,
   output logic             we,
   output logic [IDX_W-1:0] ptr
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   clr_state_t       state_reg;
   clr_state_t       state_next;
   logic [IDX_W-1:0] ptr_reg;
   logic [IDX_W-1:0] ptr_next;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= ST_CLEAR;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         ST_IDLE: begin
            ptr_next = '0;
         end
         ST_CLEAR: begin
            if (ptr_reg == LAST) begin
               state_next = ST_IDLE;
               ptr_next   = '0;
            end else begin
               ptr_next = ptr_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_CLEAR;
            ptr_next   = '0;
         end
      endcase
   end

   assign busy = (state_reg == ST_CLEAR);
   // No clear writes while reset is held, so the sweep starts on release.
   assign we   = busy & rst;
   assign ptr  = ptr_reg;

endmodule

// File: rtl/tdp_ram_param.sv
// Parametrised true dual-port RAM with collision arbitration, range checking
// and a post-reset clear sweep. Optional parity: define TDP_RAM_PARITY_EN.
module tdp_ram_param
   import tdp_ram_pkg::*;
#(
   parameter int               DATA_W    = 8,
   parameter int               DEPTH     = 20,
   parameter int               ADDR_W    = 8,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_en,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   input  logic              b_en,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid,
`ifdef TDP_RAM_PARITY_EN
   input  logic              inj_perr,
   output logic              a_perr,
   output logic              b_perr,
`endif
   output logic              init_busy,
   output logic              collision,
   output logic              oor_err
);

   localparam int              IDX_W   = idx_width(DEPTH);
   localparam bit              CFG_OK  = addr_fits(ADDR_W, DEPTH);
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
`ifdef TDP_RAM_PARITY_EN
   localparam int              MEM_W   = DATA_W + 1;
   localparam logic [MEM_W-1:0] CLEAR_WORD = {1'b0, CLEAR_VAL};
`else
   localparam int              MEM_W   = DATA_W;
   localparam logic [MEM_W-1:0] CLEAR_WORD = CLEAR_VAL;
`endif

   generate
      if (!CFG_OK) begin : g_cfg_check
         $error("tdp_ram_param: ADDR_W too small to address DEPTH words");
      end
   endgenerate

   logic [MEM_W-1:0]  mem [DEPTH];

   logic              clr_we;
   logic [IDX_W-1:0]  clr_ptr;

   logic [1:0]        en;
   logic [1:0]        we;
   logic [1:0]        req;
   logic [1:0]        ok;
   logic [1:0]        rd;
   logic [1:0]        wr;
   logic [1:0]        rvalid;
   logic              same;
   logic [ADDR_W-1:0] addr  [2];
   logic [MEM_W-1:0]  wword [2];
   logic [MEM_W-1:0]  rword [2];
   logic [IDX_W-1:0]  idx   [2];
   logic              collision_reg;
   logic              oor_reg;

   tdp_ram_clear_seq #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_clear_seq (
      .clk  (clk),
      .rst  (rst),
      .busy (init_busy),
      .we   (clr_we),
      .ptr  (clr_ptr)
   );

   assign en      = {b_en, a_en};
   assign we      = {b_we, a_we};
   assign addr[0] = a_addr;
   assign addr[1] = b_addr;
   assign same    = (a_addr == b_addr);

`ifdef TDP_RAM_PARITY_EN
   assign wword[0] = {even_parity(64'(a_wdata)) ^ inj_perr, a_wdata};
   assign wword[1] = {even_parity(64'(b_wdata)) ^ inj_perr, b_wdata};
`else
   assign wword[0] = a_wdata;
   assign wword[1] = b_wdata;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [MEM_W-1:0] rword_reg;
         logic             rvalid_reg;

         assign req[gi] = en[gi] & ~init_busy;
         assign ok[gi]  = ({1'b0, addr[gi]} < DEPTH_X);
         // Out-of-range requests are steered to word 0 so no index is ever illegal.
         assign idx[gi] = ok[gi] ? addr[gi][IDX_W-1:0] : '0;
         assign rd[gi]  = req[gi] & ~we[gi];

         always_ff @(posedge clk) begin
            if (!rst) begin
               rword_reg  <= '0;
               rvalid_reg <= 1'b0;
            end else begin
               rvalid_reg <= rd[gi];
               if (rd[gi]) begin
                  rword_reg <= ok[gi] ? mem[idx[gi]] : '0;
               end
            end
         end

         assign rword[gi]  = rword_reg;
         assign rvalid[gi] = rvalid_reg;
      end
   endgenerate

   // Port A wins a same-address write/write; port B's write is discarded.
   assign wr[0] = req[0] & we[0] & ok[0];
   assign wr[1] = req[1] & we[1] & ok[1] & ~(wr[0] & same);

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_ptr] <= CLEAR_WORD;
      end else if (rst) begin
         if (wr[0]) begin
            mem[idx[0]] <= wword[0];
         end
         if (wr[1]) begin
            mem[idx[1]] <= wword[1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         collision_reg <= 1'b0;
         oor_reg       <= 1'b0;
      end else begin
         collision_reg <= req[0] & req[1] & same & ok[0] & (we[0] | we[1]);
         oor_reg       <= |(req & ~ok);
      end
   end

   assign a_rdata   = rword[0][DATA_W-1:0];
   assign b_rdata   = rword[1][DATA_W-1:0];
   assign a_rvalid  = rvalid[0];
   assign b_rvalid  = rvalid[1];
   assign collision = collision_reg;
   assign oor_err   = oor_reg;

`ifdef TDP_RAM_PARITY_EN
   assign a_perr = rvalid[0] & (rword[0][DATA_W] != even_parity(64'(rword[0][DATA_W-1:0])));
   assign b_perr = rvalid[1] & (rword[1][DATA_W] != even_parity(64'(rword[1][DATA_W-1:0])));
`endif

endmodule

// File: tb/tb_tdp_ram_param.sv
// Directed bench for tdp_ram_param (DATA_W=8, DEPTH=20, ADDR_W=8): clear
// timing, read/write, collisions, out-of-range handling and reset mid-clear.
module tb_tdp_ram_param;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 20;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              a_en, a_we, b_en, b_we;
   logic [ADDR_W-1:0] a_addr, b_addr;
   logic [DATA_W-1:0] a_wdata, b_wdata;
   logic [DATA_W-1:0] a_rdata, b_rdata;
   logic              a_rvalid, b_rvalid;
   logic              init_busy, collision, oor_err;
`ifdef TDP_RAM_PARITY_EN
   logic              inj_perr = 1'b0;
   logic              a_perr, b_perr;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tdp_ram_param #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .CLEAR_VAL (8'h00)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .a_en      (a_en),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_rdata   (a_rdata),
      .a_rvalid  (a_rvalid),
      .b_en      (b_en),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_rdata   (b_rdata),
      .b_rvalid  (b_rvalid),
`ifdef TDP_RAM_PARITY_EN
      .inj_perr  (inj_perr),
      .a_perr    (a_perr),
      .b_perr    (b_perr),
`endif
      .init_busy (init_busy),
      .collision (collision),
      .oor_err   (oor_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step(input string what);
      $display("[%0t] txn %s", $time, what);
      tick();
   endtask

   task automatic port_a(input logic en, input logic wr, input int ad, input int wd);
      a_en = en; a_we = wr; a_addr = ADDR_W'(ad); a_wdata = DATA_W'(wd);
   endtask

   task automatic port_b(input logic en, input logic wr, input int ad, input int wd);
      b_en = en; b_we = wr; b_addr = ADDR_W'(ad); b_wdata = DATA_W'(wd);
   endtask

   task automatic idle();
      port_a(1'b0, 1'b0, 0, 0);
      port_b(1'b0, 1'b0, 0, 0);
   endtask

   int n;
   int stray;

   initial begin
      rst = 1'b0;
      idle();
      tick();
      step("reset held");
      check("rst_a_rdata", a_rdata, 0);
      check("rst_b_rdata", b_rdata, 0);
      check("rst_a_rvalid", a_rvalid, 0);
      check("rst_b_rvalid", b_rvalid, 0);
      check("rst_collision", collision, 0);
      check("rst_oor_err", oor_err, 0);
      check("rst_init_busy", init_busy, 1);

      // Clear length after release
      rst = 1'b1;
      n = 0;
      while (init_busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      $display("[%0t] txn clear done after %0d busy cycles", $time, n);
      check("clear_busy_cycles", n, DEPTH);

      // Cleared contents: A walks up, B walks down, never the same address
      for (int i = 0; i < DEPTH; i++) begin
         port_a(1'b1, 1'b0, i, 0);
         port_b(1'b1, 1'b0, DEPTH - 1 - i, 0);
         step($sformatf("A rd %0d, B rd %0d", i, DEPTH - 1 - i));
         check("clr_a_rvalid", a_rvalid, 1);
         check("clr_a_rdata", a_rdata, 0);
         check("clr_b_rvalid", b_rvalid, 1);
         check("clr_b_rdata", b_rdata, 0);
      end

      idle();
      port_a(1'b1, 1'b1, 3, 'h5A);
      step("A wr 3=5a");
      check("wr_no_rvalid", a_rvalid, 0);
      idle();
      port_b(1'b1, 1'b0, 3, 0);
      step("B rd 3");
      check("b_rd3_rvalid", b_rvalid, 1);
      check("b_rd3_rdata", b_rdata, 'h5A);
      check("b_rd3_collision", collision, 0);
      idle();
      step("idle");
      check("idle_b_rvalid", b_rvalid, 0);
      check("idle_b_rdata_hold", b_rdata, 'h5A);

      // Write/write collision: port A wins
      port_a(1'b1, 1'b1, 7, 'h11);
      port_b(1'b1, 1'b1, 7, 'h22);
      step("A wr 7=11, B wr 7=22");
      check("ww_collision", collision, 1);
      idle();
      step("idle");
      check("ww_collision_once", collision, 0);
      port_a(1'b1, 1'b0, 7, 0);
      port_b(1'b1, 1'b0, 7, 0);
      step("A rd 7, B rd 7");
      check("ww_a_rdata", a_rdata, 'h11);
      check("ww_b_rdata", b_rdata, 'h11);
      check("rr_no_collision", collision, 0);

      // Read/write collisions in both port orders
      idle();
      port_a(1'b1, 1'b1, 4, 'hAA);
      step("A wr 4=aa");
      port_a(1'b1, 1'b0, 4, 0);
      port_b(1'b1, 1'b1, 4, 'h55);
      step("A rd 4, B wr 4=55");
      check("rw_a_rdata_old", a_rdata, 'hAA);
      check("rw_a_rvalid", a_rvalid, 1);
      check("rw_b_rvalid", b_rvalid, 0);
      check("rw_collision", collision, 1);
      port_a(1'b1, 1'b1, 4, 'h66);
      port_b(1'b1, 1'b0, 4, 0);
      step("A wr 4=66, B rd 4");
      check("wr_b_rdata_old", b_rdata, 'h55);
      check("wr_collision", collision, 1);
      idle();
      port_a(1'b1, 1'b0, 4, 0);
      step("A rd 4");
      check("wr_a_rdata_new", a_rdata, 'h66);
      check("wr_no_collision", collision, 0);

      // Out-of-range accesses
      idle();
      port_a(1'b1, 1'b1, 25, 'h77);
      step("A wr 25=77");
      check("oor_wr_pulse", oor_err, 1);
      check("oor_wr_no_rvalid", a_rvalid, 0);
      port_a(1'b1, 1'b1, 35, 'h77);
      step("A wr 35=77");
      check("oor_wr35_pulse", oor_err, 1);
      port_a(1'b1, 1'b0, 3, 0);
      step("A rd 3");
      check("oor_no_alias", a_rdata, 'h5A);
      check("oor_clear_after", oor_err, 0);
      port_a(1'b1, 1'b0, 25, 0);
      step("A rd 25");
      check("oor_rd_rvalid", a_rvalid, 1);
      check("oor_rd_rdata", a_rdata, 0);
      check("oor_rd_pulse", oor_err, 1);
      idle();
      port_b(1'b1, 1'b0, DEPTH, 0);
      step("B rd 20");
      check("oor_b20_rvalid", b_rvalid, 1);
      check("oor_b20_rdata", b_rdata, 0);
      check("oor_b20_pulse", oor_err, 1);
      port_b(1'b1, 1'b1, DEPTH - 1, 'h99);
      step("B wr 19=99");
      check("last_wr_no_oor", oor_err, 0);
      idle();
      port_a(1'b1, 1'b0, DEPTH - 1, 0);
      step("A rd 19");
      check("last_rd_rdata", a_rdata, 'h99);

      // Reset mid-clear, with requests pending throughout the restarted clear
      idle();
      rst = 1'b0;
      step("reset");
      rst = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("midclear_busy", init_busy, 1);
      rst = 1'b0;
      step("reset mid-clear");
      rst = 1'b1;
      n = 0;
      stray = 0;
      while (init_busy === 1'b1 && n < 100) begin
         n++;
         port_a(1'b1, 1'b0, (n % 2) ? 25 : 5, 0);
         port_b(1'b1, 1'b1, 5, 'hFF);
         tick();
         if (a_rvalid || b_rvalid || collision || oor_err) stray++;
      end
      $display("[%0t] txn restarted clear done after %0d busy cycles", $time, n);
      check("restart_busy_cycles", n, DEPTH);
      check("busy_no_activity", stray, 0);
      idle();
      port_a(1'b1, 1'b0, 3, 0);
      port_b(1'b1, 1'b0, DEPTH - 1, 0);
      step("A rd 3, B rd 19");
      check("reclr_a_rdata", a_rdata, 0);
      check("reclr_b_rdata", b_rdata, 0);
      check("reclr_a_rvalid", a_rvalid, 1);
      port_a(1'b1, 1'b0, 5, 0);
      port_b(1'b0, 1'b0, 0, 0);
      step("A rd 5");
      check("busy_write_dropped", a_rdata, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
